// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Widths, saturation limits and FSM states for the div19sx8s divider
// Revision : 1.0
// ============================================================================
package div_pkg;

  localparam int DW   = 19;
  localparam int VW   = 8;
  localparam int QW   = 11;
  localparam int QMAX = 1023;
  localparam int QMIN = -1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    SIGN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division iteration
// Revision : 1.0
// ============================================================================
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   rem_o,
  output logic          q_o
);

  logic [VW+1:0] shift;
  logic [VW+1:0] trial;

  // rem_i < dvs_i holds between iterations, so the trial MSB is a clean sign bit
  always_comb begin
    shift = {rem_i, bit_i};
    trial = shift - {2'b00, dvs_i};
    q_o   = ~trial[VW+1];
    rem_o = q_o ? trial[VW:0] : shift[VW:0];
  end

endmodule
`default_nettype wire

// File: rtl/div19sx8s.sv
`default_nettype none
// ============================================================================
// Module   : div19sx8s
// Brief    : Sequential signed restoring divider, 19-bit / 8-bit -> 11-bit quotient
// Revision : 1.0
// ============================================================================
module div19sx8s #(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW,
  parameter int QW = div_pkg::QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  output logic [QW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  import div_pkg::*;

  localparam int            CW        = $clog2(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [DW-1:0] POS_LIM   = DW'(QMAX);
  localparam logic [DW-1:0] NEG_LIM   = DW'(-QMIN);
  localparam logic [QW-1:0] SAT_POS   = QW'(QMAX);
  localparam logic [QW-1:0] SAT_NEG   = QW'(QMIN);

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dzo_q, dzo_d;
  logic          ovf_q, ovf_d;
  logic          vld_q, vld_d;

  logic [VW:0]   step_rem;
  logic          step_q;
  logic          q_over;
  logic [QW-1:0] q_mag;

  div_step #(.VW(VW)) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = DIV;
      DIV:     if (cnt_q == LAST_ITER) state_d = SIGN;
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dvd_q holds the raw dividend, then its magnitude, and finally the quotient
  // magnitude as quotient bits are shifted in behind the consumed dividend bits.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dzo_d  = dzo_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    q_over = qneg_q ? (dvd_q > NEG_LIM) : (dvd_q > POS_LIM);
    q_mag  = dvd_q[QW-1:0];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
        end
      end
      LOAD: begin
        dvd_d  = dvd_q[DW-1] ? -dvd_q : dvd_q;
        dvs_d  = dvs_q[VW-1] ? -dvs_q : dvs_q;
        qneg_d = dvd_q[DW-1] ^ dvs_q[VW-1];
        rneg_d = dvd_q[DW-1];
        dz_d   = (dvs_q == '0);
        prem_d = '0;
        cnt_d  = '0;
      end
      DIV: begin
        dvd_d  = {dvd_q[DW-2:0], step_q};
        prem_d = step_rem;
        cnt_d  = cnt_q + 1'b1;
      end
      SIGN: begin
        vld_d = 1'b1;
        if (dz_q) begin
          quot_d = '0;
          rem_d  = '0;
          dzo_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          dzo_d  = 1'b0;
          ovf_d  = q_over;
          if (q_over) quot_d = qneg_q ? SAT_NEG : SAT_POS;
          else        quot_d = qneg_q ? -q_mag : q_mag;
          rem_d  = rneg_q ? -prem_q[VW-1:0] : prem_q[VW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dzo_q  <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dzo_q  <= dzo_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = vld_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div19sx8s.sv
`default_nettype none
// ============================================================================
// Module   : tb_div19sx8s
// Brief    : Directed vector table plus handshake/reset sequences for div19sx8s
// Revision : 1.0
// ============================================================================
module tb_div19sx8s;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [18:0] dividend;
  logic signed [7:0]  divisor;
  logic               out_valid;
  logic signed [10:0] quotient;
  logic signed [7:0]  remainder;
  logic               div_by_zero;
  logic               overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div19sx8s dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int ov;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns edges from accept to the out_valid cycle (-1 on timeout)
  task automatic run_div(input int a, input int b, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    dividend = 19'(a);
    divisor  = 8'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 19'($urandom);
    divisor  = 8'($urandom);
    check("ready_drop", in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) lat = -1;
    check("ready_at_valid", in_ready, 1);
    @(posedge clk);
    #1;
    check("valid_one_pulse", out_valid, 0);
  endtask

  initial begin
    int lat, n, t1, t2, t3, seen, a_i, b_i;

    vecs[0]  = '{1000, 7, 142, 6, 0, 0};
    vecs[1]  = '{-1000, 7, -142, -6, 0, 0};
    vecs[2]  = '{1000, -7, -142, 6, 0, 0};
    vecs[3]  = '{-1000, -7, 142, -6, 0, 0};
    vecs[4]  = '{131072, -128, -1024, 0, 0, 0};
    vecs[5]  = '{262143, -1, -1024, 0, 0, 1};
    vecs[6]  = '{-262144, -128, 1023, 0, 0, 1};
    vecs[7]  = '{5, 0, 0, 0, 1, 0};
    vecs[8]  = '{-262144, 0, 0, 0, 1, 0};
    vecs[9]  = '{0, -7, 0, 0, 0, 0};
    vecs[10] = '{-7, 100, 0, -7, 0, 0};
    vecs[11] = '{102300, 100, 1023, 0, 0, 0};
    vecs[12] = '{102400, 100, 1023, 0, 0, 1};
    vecs[13] = '{-102400, 100, -1024, 0, 0, 0};
    vecs[14] = '{-262144, 127, -1024, -16, 0, 1};
    vecs[15] = '{-131072, -128, 1023, 0, 0, 1};
    vecs[16] = '{1000, 1, 1000, 0, 0, 0};

    rst      = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, 21);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dz);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
    end

    // Abort at DIV iteration 10: accept edge, LOAD edge, then iterations 0..9
    @(negedge clk);
    dividend = 19'sd1000;
    divisor  = 8'sd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_div(-1000, 7, lat);
    check("post_abort_latency", lat, 21);
    check("post_abort_quotient", quotient, -142);
    check("post_abort_remainder", remainder, -6);

    // Reset wins over a simultaneous in_valid
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = 19'sd1000;
    divisor  = 8'sd7;
    @(posedge clk);
    #1;
    check("rst_prio_ready", in_ready, 1);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_prio_idle", in_ready, 1);

    // Back-to-back with in_valid held high
    @(negedge clk);
    dividend = 19'sd1000;
    divisor  = 8'sd7;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 60);
    check("b2b_valid1", out_valid, 1);
    t1 = cyc;
    check("b2b_q1", quotient, 142);
    dividend = -19'sd1000;
    divisor  = -8'sd7;
    @(posedge clk);
    #1;
    check("b2b_accept2", in_ready, 0);
    dividend = 19'sd12345;
    divisor  = 8'sd3;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 60);
    check("b2b_valid2", out_valid, 1);
    t2 = cyc;
    check("b2b_period2", t2 - t1, 22);
    check("b2b_q2", quotient, 142);
    check("b2b_r2", remainder, -6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 60);
    check("b2b_valid3", out_valid, 1);
    t3 = cyc;
    check("b2b_period3", t3 - t2, 22);
    check("b2b_q3", quotient, 1023);
    check("b2b_r3", remainder, 0);
    check("b2b_ovf3", overflow, 1);

    // Products of 11x8 signed operands divide back exactly
    for (int k = 0; k < 8; k++) begin
      a_i = int'($urandom_range(0, 2047)) - 1024;
      do b_i = int'($urandom_range(0, 255)) - 128; while (b_i == 0);
      run_div(a_i * b_i, b_i, lat);
      check($sformatf("mul%0d_quotient", k), quotient, a_i);
      check($sformatf("mul%0d_remainder", k), remainder, 0);
      check($sformatf("mul%0d_ovf", k), overflow, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
